mem_access_stage: RTL

//  MEM stage of the pipeline. Consumes EX/MEM latch outputs, owns the data memory, performs byte/half/word

---
 rtl/mem_access_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: owns data memory, performs B/H/W loads and stores, and
// offers a ready/valid word-by-word memory dump for the debug unit.
module mem_access_stage #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 5
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [2:0]         i_funct3,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_DATA-1:0] i_write_data,
    input  logic [1:0]         i_pipeline_mode,
    input  logic               i_run_clockcycle,
    input  logic               i_dump_req,
    input  logic               i_dump_ready,
    output logic [NB_DATA-1:0] o_read_data,
    output logic               o_misaligned,
    output logic               o_fault,
    output logic               o_dump_valid,
    output logic [NB_ADDR-1:0] o_dump_addr,
    output logic [NB_DATA-1:0] o_dump_data,
    output logic               o_dump_done,
    output logic               o_busy
);
    localparam int unsigned Depth   = 2 ** NB_ADDR;
    localparam int unsigned NbLanes = NB_DATA / 8;

    typedef enum logic [1:0] {StIdle, StDump, StDone} state_e;

    state_e               state_q, state_d;
    logic [NB_ADDR-1:0]   cnt_q, cnt_d;
    logic                 fault_q, fault_d;
    logic [NB_DATA-1:0]   mem_q [Depth];

    logic                 en;
    logic [NB_ADDR-1:0]   word_idx;
    logic [1:0]           offset;
    logic                 is_byte, is_half, is_word, is_signed;
    logic [NB_DATA-1:0]   cur_word, shifted;
    logic                 wr_en;
    logic [NbLanes-1:0]   lane_mask;
    logic [NB_DATA-1:0]   wr_rep, mem_wdata;
    logic                 unused_addr;

    assign en          = (i_pipeline_mode == 2'b01) ||
                         ((i_pipeline_mode == 2'b11) && i_run_clockcycle);
    assign word_idx    = i_alu_result[NB_ADDR+1:2];
    assign offset      = i_alu_result[1:0];
    assign unused_addr = ^i_alu_result[NB_DATA-1:NB_ADDR+2];

    // Undefined funct3 encodings fall through to word accesses.
    assign is_byte   = (i_funct3 == 3'b000) || (i_funct3 == 3'b100);
    assign is_half   = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    assign is_word   = !is_byte && !is_half;
    assign is_signed = !i_funct3[2];

    assign o_misaligned = (is_half && offset[0]) || (is_word && (offset != 2'b00));

    assign cur_word = mem_q[word_idx];
    assign shifted  = cur_word >> {offset, 3'b000};

    always_comb begin
        o_read_data = '0;
        if (i_mem_read && !o_misaligned) begin
            if (is_byte) begin
                o_read_data = {{(NB_DATA-8){is_signed & shifted[7]}}, shifted[7:0]};
            end else if (is_half) begin
                o_read_data = {{(NB_DATA-16){is_signed & shifted[15]}}, shifted[15:0]};
            end else begin
                o_read_data = cur_word;
            end
        end
    end

    assign wr_en = en && i_mem_write && !o_misaligned && (state_q == StIdle);

    always_comb begin
        lane_mask = '1;
        wr_rep    = i_write_data;
        if (is_byte) begin
            lane_mask = {{(NbLanes-1){1'b0}}, 1'b1} << offset;
            wr_rep    = {NbLanes{i_write_data[7:0]}};
        end else if (is_half) begin
            lane_mask = {{(NbLanes-2){1'b0}}, 2'b11} << offset;
            wr_rep    = {(NbLanes/2){i_write_data[15:0]}};
        end
        for (int l = 0; l < int'(NbLanes); l++) begin
            mem_wdata[8*l +: 8] = lane_mask[l] ? wr_rep[8*l +: 8] : cur_word[8*l +: 8];
        end
    end

    assign fault_d = fault_q || (en && (i_mem_read || i_mem_write) && o_misaligned);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (i_dump_req && !en) begin
                    state_d = StDump;
                end
            end
            StDump: begin
                if (i_dump_ready) begin
                    if (&cnt_q) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            if (wr_en) begin
                mem_q[word_idx] <= mem_wdata;
            end
        end
    end

    assign o_fault      = fault_q;
    assign o_dump_valid = (state_q == StDump);
    assign o_dump_addr  = cnt_q;
    assign o_dump_data  = o_dump_valid ? mem_q[cnt_q] : '0;
    assign o_dump_done  = (state_q == StDone);
    assign o_busy       = (state_q != StIdle);
endmodule
